tx_req_arbiter: RTL

TX_REQ_ARBITER -- requirements
Module: tx_req_arbiter

---
 rtl/tx_req_arbiter_if.sv | 24 ++
 rtl/tx_req_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_req_arbiter_if.sv
// Downstream request channel of tx_req_arbiter: one granted read/write
// request offered with a valid/ready handshake.
interface tx_req_arbiter_if #(
    parameter int C_ADDR_W = 64,
    parameter int C_LEN_W  = 10
);
    logic                REQ_VALID;
    logic                REQ_READY;
    logic                REQ_WRITE;
    logic [3:0]          REQ_CHNL;
    logic [C_ADDR_W-1:0] REQ_ADDR;
    logic [C_LEN_W-1:0]  REQ_LEN;
    logic [1:0]          REQ_SG_CHNL;

    modport master (
        output REQ_VALID, REQ_WRITE, REQ_CHNL, REQ_ADDR, REQ_LEN, REQ_SG_CHNL,
        input  REQ_READY
    );

    modport slave (
        input  REQ_VALID, REQ_WRITE, REQ_CHNL, REQ_ADDR, REQ_LEN, REQ_SG_CHNL,
        output REQ_READY
    );
endinterface

// File: rtl/tx_req_arbiter.sv
// Round-robin arbiter over per-channel write/read slots, with write-packet
// credit tracking and a registered IDLE/OFFER/ACK grant sequence.
module tx_req_arbiter #(
    parameter int C_NUM_CHNL      = 12,
    parameter int C_DEPTH_PACKETS = 10,
    parameter int C_ADDR_W        = 64,
    parameter int C_LEN_W         = 10
) (
    input  logic                                   CLK,
    input  logic                                   RST_IN,
    input  logic [C_NUM_CHNL-1:0]                  WR_REQ,
    input  logic [C_NUM_CHNL*C_ADDR_W-1:0]         WR_ADDR,
    input  logic [C_NUM_CHNL*C_LEN_W-1:0]          WR_LEN,
    output logic [C_NUM_CHNL-1:0]                  WR_ACK,
    input  logic [C_NUM_CHNL-1:0]                  RD_REQ,
    input  logic [C_NUM_CHNL*C_ADDR_W-1:0]         RD_ADDR,
    input  logic [C_NUM_CHNL*C_LEN_W-1:0]          RD_LEN,
    input  logic [C_NUM_CHNL*2-1:0]                RD_SG_CHNL,
    output logic [C_NUM_CHNL-1:0]                  RD_ACK,
    input  logic                                   RXBUF_SPACE_AVAIL,
    input  logic                                   WR_DONE,
    tx_req_arbiter_if.master                       req_if,
    output logic [$clog2(C_DEPTH_PACKETS+1)-1:0]   WR_CREDITS
);

    localparam int NSLOT = 2 * C_NUM_CHNL;
    localparam int SW    = $clog2(NSLOT);
    localparam int CW    = $clog2(C_DEPTH_PACKETS + 1);

    localparam logic [SW:0]   NSLOT_X   = (SW+1)'(NSLOT);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NSLOT - 1);
    localparam logic [CW-1:0] CRED_MAX  = CW'(C_DEPTH_PACKETS);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        ACK
    } state_e;

    state_e                state_q;
    logic [SW-1:0]         ptr_q,  ptr_d;
    logic [SW-1:0]         slot_q;
    logic [CW-1:0]         credits_q, credits_d;
    logic                  valid_q;
    logic                  write_q;
    logic [3:0]            chnl_q;
    logic [C_ADDR_W-1:0]   addr_q;
    logic [C_LEN_W-1:0]    len_q;
    logic [1:0]            sg_q;
    logic [C_NUM_CHNL-1:0] wr_ack_q;
    logic [C_NUM_CHNL-1:0] rd_ack_q;

    logic [NSLOT-1:0]      elig;
    logic                  pick_found;
    logic [SW-1:0]         pick_slot;
    logic [SW-1:0]         pick_ch;
    logic                  pick_wr;
    logic [C_ADDR_W-1:0]   pick_addr;
    logic [C_LEN_W-1:0]    pick_len;
    logic [1:0]            pick_sg;
    logic [SW:0]           scan_sum;
    logic [SW-1:0]         scan_idx;
    logic [C_NUM_CHNL-1:0] ack_vec;
    logic                  accept;
    logic                  accept_wr;

    always_comb begin
        elig = '0;
        for (int unsigned c = 0; c < C_NUM_CHNL; c++) begin
            elig[2*c]   = WR_REQ[c] && (credits_q != '0);
            elig[2*c+1] = RD_REQ[c] && RXBUF_SPACE_AVAIL;
        end
    end

    // Scan from the pointer upwards; the sum is folded back by one slot
    // count so non-power-of-2 slot counts never index past the last slot.
    always_comb begin
        pick_found = 1'b0;
        pick_slot  = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int unsigned k = 0; k < NSLOT; k++) begin
            scan_sum = {1'b0, ptr_q} + (SW+1)'(k);
            if (scan_sum >= NSLOT_X) begin
                scan_sum = scan_sum - NSLOT_X;
            end
            scan_idx = scan_sum[SW-1:0];
            if (!pick_found && elig[scan_idx]) begin
                pick_found = 1'b1;
                pick_slot  = scan_idx;
            end
        end
    end

    assign pick_ch = pick_slot >> 1;
    assign pick_wr = ~pick_slot[0];

    always_comb begin
        pick_addr = '0;
        pick_len  = '0;
        pick_sg   = '0;
        for (int unsigned c = 0; c < C_NUM_CHNL; c++) begin
            if (pick_ch == SW'(c)) begin
                if (pick_wr) begin
                    pick_addr = WR_ADDR[c*C_ADDR_W +: C_ADDR_W];
                    pick_len  = WR_LEN[c*C_LEN_W +: C_LEN_W];
                end else begin
                    pick_addr = RD_ADDR[c*C_ADDR_W +: C_ADDR_W];
                    pick_len  = RD_LEN[c*C_LEN_W +: C_LEN_W];
                    pick_sg   = RD_SG_CHNL[2*c +: 2];
                end
            end
        end
    end

    always_comb begin
        ack_vec = '0;
        for (int unsigned c = 0; c < C_NUM_CHNL; c++) begin
            ack_vec[c] = (chnl_q == 4'(c));
        end
    end

    assign accept    = (state_q == OFFER) && req_if.REQ_READY;
    assign accept_wr = accept && write_q;
    assign ptr_d     = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;

    // A write accept and a WR_DONE in the same cycle cancel out.
    always_comb begin
        credits_d = credits_q;
        if (accept_wr && !WR_DONE) begin
            credits_d = credits_q - 1'b1;
        end else if (WR_DONE && !accept_wr && (credits_q != CRED_MAX)) begin
            credits_d = credits_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_IN) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            slot_q    <= '0;
            credits_q <= CRED_MAX;
            valid_q   <= 1'b0;
            write_q   <= 1'b0;
            chnl_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            sg_q      <= '0;
            wr_ack_q  <= '0;
            rd_ack_q  <= '0;
        end else begin
            credits_q <= credits_d;
            wr_ack_q  <= '0;
            rd_ack_q  <= '0;
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        write_q <= pick_wr;
                        chnl_q  <= 4'(pick_ch);
                        addr_q  <= pick_addr;
                        len_q   <= pick_len;
                        sg_q    <= pick_sg;
                        slot_q  <= pick_slot;
                        valid_q <= 1'b1;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    if (req_if.REQ_READY) begin
                        valid_q <= 1'b0;
                        ptr_q   <= ptr_d;
                        state_q <= ACK;
                        if (write_q) begin
                            wr_ack_q <= ack_vec;
                        end else begin
                            rd_ack_q <= ack_vec;
                        end
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_if.REQ_VALID   = valid_q;
    assign req_if.REQ_WRITE   = write_q;
    assign req_if.REQ_CHNL    = chnl_q;
    assign req_if.REQ_ADDR    = addr_q;
    assign req_if.REQ_LEN     = len_q;
    assign req_if.REQ_SG_CHNL = sg_q;
    assign WR_ACK             = wr_ack_q;
    assign RD_ACK             = rd_ack_q;
    assign WR_CREDITS         = credits_q;

endmodule
